fp_reciprocal_post: RTL and testbench
=====================================

FP_RECIPROCAL_POST -- requirements
Module: fp_reciprocal_post

Interface
REQ-001 SHALL have parameter LATENCY, default 15, meaning the cycles from sideband issue to mantissa-result arrival.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-004 SHALL have port valid_data_in, input, 1, sideband issue strobe, same cycle as the operand entering the mantissa pipeline.
REQ-005 SHALL have port exponent_in, input, 8, biased exponent of the operand.
REQ-006 SHALL have port special_case_in, input, 1, operand is zero/inf/NaN/flushed-denorm.
REQ-007 SHALL have port special_result_in, input, 32, fp32 result used when special_case_in=1.
REQ-008 SHALL have ports invalid_in and div_by_zero_in, input, 1 each, exception flags for the special result.
REQ-009 SHALL have port m_valid, input, 1, mantissa result valid.
REQ-010 SHALL have ports m_mant, input, 23, and m_out_is_1, m_guard, m_round, m_sticky, m_sign, input, 1 each, mantissa result fields.
REQ-011 SHALL have port m_rounding_mode, input, 3, rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM).
REQ-012 SHALL have ports out, output, 32, and valid_data_out, output, 1, for the final fp32 result.
REQ-013 SHALL have ports overflow, underflow, inexact, invalid_operation, div_by_zero, output, 1 each, for the result flags.
REQ-014 SHALL have port sync_error, output, 1, sticky sideband/mantissa misalignment.

Function
REQ-015 SHALL delay the sideband (valid, exponent, special, result, flags) by exactly LATENCY cycles through a shift register.
REQ-016 SHALL register outputs 2 cycles after m_valid: stage R (exponent, round increment) and stage P (pack, flags).
REQ-017 SHALL accept one result per cycle with no stalls, and SHALL hold back-to-back and bubbled streams independently.
REQ-018 SHALL compute the biased exponent as 254-e when m_out_is_1=1, else 253-e, in signed 10-bit arithmetic.
REQ-019 SHALL apply the increment: RNE g&(r|s|lsb); RTZ none; RDN sign&(g|r|s); RUP ~sign&(g|r|s); RMM g; codes 5-7 behave as RNE.
REQ-020 SHALL, on a mantissa carry-out of 0x7FFFFF, set the mantissa to 0 and add 1 to the exponent.
REQ-021 SHALL, when the pre-round exponent is <=0, flush to a signed zero and set underflow=1 and inexact=1.
REQ-022 SHALL, when the post-round exponent is >=255, output a signed inf and set overflow=1 and inexact=1.
REQ-023 SHALL otherwise set inexact=g|r|s.
REQ-024 SHALL, when the delayed special flag is 1, output special_result with the delayed invalid/div_by_zero flags and all other flags 0.
REQ-025 SHALL take the result sign from m_sign; special results carry their own sign.
REQ-026 SHALL hold out and the flags at their last values while valid_data_out=0.

Reset
REQ-027 SHALL, on rst, clear all outputs, sync_error and every delay/pipeline register to 0.
REQ-028 SHALL, after reset deassertion mid-stream, produce valid_data_out=0 until new issues propagate, with no stale results.

Configuration
REQ-029 SHALL, with FP_RECIP_SYNC_CHECK_EN defined, set sync_error (sticky until rst) when m_valid differs from the delayed valid_data_in in any cycle.
REQ-030 SHALL, without FP_RECIP_SYNC_CHECK_EN, tie sync_error to 0 and synthesize no checker logic.

Structure
REQ-031 SHALL take fp_32b_t, the rounding-mode enum and the constants FP_QNAN=0x7FC00000 and FP_INF=0x7F800000 from fp_pkg.
REQ-032 SHALL place the parameterized shift register in a sub-module named fp_sideband_delay (WIDTH, DEPTH).

Verification
REQ-033 SHALL cover: e=128, m_out_is_1=1, mant 0, g/r/s 0 -> out 0x3F000000, no flags, 2 cycles after m_valid.
REQ-034 SHALL cover: e=127, out_is_1=0, mant 0x2AAAAA, g=1 r=0 s=1 -> RNE 0x3F2AAAAB, RTZ 0x3F2AAAAA, inexact=1.
REQ-035 SHALL cover: e=254, out_is_1=0, sign 1 -> out 0x80000000, underflow=1, inexact=1.
REQ-036 SHALL cover: special result 0x7FC00000 with invalid_in -> out 0x7FC00000, invalid_operation=1; special 0x7F800000 with div_by_zero_in -> div_by_zero=1.
REQ-037 SHALL cover: 20 back-to-back issues with rst pulsed at issue 10 -> outputs 0, no spurious valid, correct results for post-reset issues.
REQ-038 SHALL cover: m_valid=1 with no issue LATENCY cycles earlier -> sync_error=1 held until rst (macro on); stays 0 (macro off).

Source files
------------

// File: rtl/fp_pkg.sv
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Shared fp32 types, rounding modes and constants.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exponent;
      logic [22:0] mantissa;
   } fp_32b_t;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } round_mode_e;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP_INF  = 32'h7F80_0000;

   typedef struct packed {
      logic        valid;
      logic [7:0]  exponent;
      logic        special;
      logic [31:0] special_result;
      logic        invalid;
      logic        div_by_zero;
   } sideband_t;

   localparam int SB_WIDTH = $bits(sideband_t);

   // Unlisted mode codes fall back to round-to-nearest-even.
   function automatic logic round_increment(input round_mode_e mode,
                                            input logic sign,
                                            input logic lsb,
                                            input logic guard,
                                            input logic round,
                                            input logic sticky);
      logic inc;
      case (mode)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (guard | round | sticky);
         RM_RUP:  inc = ~sign & (guard | round | sticky);
         RM_RMM:  inc = guard;
         default: inc = guard & (round | sticky | lsb);
      endcase
      return inc;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fp_sideband_delay.sv
// ============================================================================
//  Module   : fp_sideband_delay
//  Purpose  : Fixed-depth shift register (DEPTH >= 1), cleared on reset.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fp_sideband_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

   generate
      if (DEPTH == 1) begin : g_single
         always_ff @(posedge clk or posedge rst) begin
            if (rst) pipe_q <= '0;
            else     pipe_q <= d_i;
         end
      end else begin : g_multi
         always_ff @(posedge clk or posedge rst) begin
            if (rst) pipe_q <= '0;
            else     pipe_q <= {pipe_q[DEPTH-2:0], d_i};
         end
      end
   endgenerate

   assign q_o = pipe_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/fp_reciprocal_post.sv
// ============================================================================
//  Module   : fp_reciprocal_post
//  Purpose  : Reciprocal post-processing: exponent, rounding, packing, flags.
//             Optional misalignment checker: FP_RECIP_SYNC_CHECK_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fp_reciprocal_post
   import fp_pkg::*;
#(
   parameter int LATENCY = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_data_in,
   input  logic [7:0]  exponent_in,
   input  logic        special_case_in,
   input  logic [31:0] special_result_in,
   input  logic        invalid_in,
   input  logic        div_by_zero_in,
   input  logic        m_valid,
   input  logic [22:0] m_mant,
   input  logic        m_out_is_1,
   input  logic        m_guard,
   input  logic        m_round,
   input  logic        m_sticky,
   input  logic        m_sign,
   input  logic [2:0]  m_rounding_mode,
   output logic [31:0] out,
   output logic        valid_data_out,
   output logic        overflow,
   output logic        underflow,
   output logic        inexact,
   output logic        invalid_operation,
   output logic        div_by_zero,
   output logic        sync_error
);

   sideband_t             sb_in;
   sideband_t             sb_dly;
   logic [SB_WIDTH-1:0]   sb_dly_bits;

   assign sb_in = '{valid:          valid_data_in,
                    exponent:       exponent_in,
                    special:        special_case_in,
                    special_result: special_result_in,
                    invalid:        invalid_in,
                    div_by_zero:    div_by_zero_in};

   fp_sideband_delay #(
      .WIDTH (SB_WIDTH),
      .DEPTH (LATENCY)
   ) u_sideband_delay (
      .clk (clk),
      .rst (rst),
      .d_i (sb_in),
      .q_o (sb_dly_bits)
   );

   assign sb_dly = sideband_t'(sb_dly_bits);

   // Stage R: exponent and rounding decision
   logic signed [9:0] rnd_exp_d, rnd_exp_q;
   logic              rnd_inc_d, rnd_inc_q;
   logic              rnd_valid_q, rnd_special_q, rnd_invalid_q, rnd_dbz_q;
   logic              rnd_sign_q, rnd_inexact_q;
   logic [31:0]       rnd_result_q;
   logic [22:0]       rnd_mant_q;

   always_comb begin
      rnd_exp_d = (m_out_is_1 ? 10'sd254 : 10'sd253) - $signed({2'b00, sb_dly.exponent});
      rnd_inc_d = round_increment(round_mode_e'(m_rounding_mode), m_sign, m_mant[0],
                                  m_guard, m_round, m_sticky);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rnd_valid_q   <= 1'b0;
         rnd_special_q <= 1'b0;
         rnd_result_q  <= '0;
         rnd_invalid_q <= 1'b0;
         rnd_dbz_q     <= 1'b0;
         rnd_exp_q     <= '0;
         rnd_mant_q    <= '0;
         rnd_inc_q     <= 1'b0;
         rnd_sign_q    <= 1'b0;
         rnd_inexact_q <= 1'b0;
      end else begin
         rnd_valid_q   <= sb_dly.valid;
         rnd_special_q <= sb_dly.special;
         rnd_result_q  <= sb_dly.special_result;
         rnd_invalid_q <= sb_dly.invalid;
         rnd_dbz_q     <= sb_dly.div_by_zero;
         rnd_exp_q     <= rnd_exp_d;
         rnd_mant_q    <= m_mant;
         rnd_inc_q     <= rnd_inc_d;
         rnd_sign_q    <= m_sign;
         rnd_inexact_q <= m_guard | m_round | m_sticky;
      end
   end

   // Stage P: apply increment, pack, flags; outputs hold between results
   logic [23:0]       mant_sum;
   logic signed [9:0] exp_post;
   fp_32b_t           res;
   logic [31:0]       out_d, out_q;
   logic              ov_d, uf_d, ix_d, io_d, dz_d;
   logic              ov_q, uf_q, ix_q, io_q, dz_q, vld_q;

   always_comb begin
      mant_sum = {1'b0, rnd_mant_q} + 24'(rnd_inc_q);
      exp_post = rnd_exp_q + $signed({9'd0, mant_sum[23]});
      res      = '0;
      out_d    = out_q;
      ov_d     = ov_q;
      uf_d     = uf_q;
      ix_d     = ix_q;
      io_d     = io_q;
      dz_d     = dz_q;
      if (rnd_valid_q) begin
         ov_d = 1'b0;
         uf_d = 1'b0;
         ix_d = 1'b0;
         io_d = 1'b0;
         dz_d = 1'b0;
         if (rnd_special_q) begin
            out_d = rnd_result_q;
            io_d  = rnd_invalid_q;
            dz_d  = rnd_dbz_q;
         end else if (rnd_exp_q <= 10'sd0) begin
            res.sign = rnd_sign_q;
            out_d    = res;
            uf_d     = 1'b1;
            ix_d     = 1'b1;
         end else if (exp_post >= 10'sd255) begin
            res      = fp_32b_t'(FP_INF);
            res.sign = rnd_sign_q;
            out_d    = res;
            ov_d     = 1'b1;
            ix_d     = 1'b1;
         end else begin
            res.sign     = rnd_sign_q;
            res.exponent = exp_post[7:0];
            res.mantissa = mant_sum[22:0];
            out_d        = res;
            ix_d         = rnd_inexact_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         vld_q <= 1'b0;
         ov_q  <= 1'b0;
         uf_q  <= 1'b0;
         ix_q  <= 1'b0;
         io_q  <= 1'b0;
         dz_q  <= 1'b0;
      end else begin
         out_q <= out_d;
         vld_q <= rnd_valid_q;
         ov_q  <= ov_d;
         uf_q  <= uf_d;
         ix_q  <= ix_d;
         io_q  <= io_d;
         dz_q  <= dz_d;
      end
   end

   assign out               = out_q;
   assign valid_data_out    = vld_q;
   assign overflow          = ov_q;
   assign underflow         = uf_q;
   assign inexact           = ix_q;
   assign invalid_operation = io_q;
   assign div_by_zero       = dz_q;

`ifdef FP_RECIP_SYNC_CHECK_EN
   logic sync_error_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          sync_error_q <= 1'b0;
      else if (m_valid != sb_dly.valid) sync_error_q <= 1'b1;
   end

   assign sync_error = sync_error_q;
`else
   logic unused_m_valid;

   assign unused_m_valid = m_valid;
   assign sync_error     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_reciprocal_post.sv
// ============================================================================
//  Module   : tb_fp_reciprocal_post
//  Purpose  : Self-checking bench for fp_reciprocal_post.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fp_reciprocal_post;

   localparam int L = 15;
   localparam int N = 2048;

   typedef struct packed {
      logic [7:0]  e;
      logic        special;
      logic [31:0] sres;
      logic        inv;
      logic        dbz;
      logic [22:0] mant;
      logic        is1;
      logic        g;
      logic        r;
      logic        s;
      logic        sign;
      logic [2:0]  rm;
   } op_t;

   typedef struct packed {
      logic [31:0] out;
      logic        ov;
      logic        uf;
      logic        ix;
      logic        io;
      logic        dz;
   } res_t;

   typedef struct packed {
      op_t  op;
      res_t ex;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_data_in, special_case_in, invalid_in, div_by_zero_in;
   logic [7:0]  exponent_in;
   logic [31:0] special_result_in;
   logic        m_valid, m_out_is_1, m_guard, m_round, m_sticky, m_sign;
   logic [22:0] m_mant;
   logic [2:0]  m_rounding_mode;
   logic [31:0] out;
   logic        valid_data_out, overflow, underflow, inexact;
   logic        invalid_operation, div_by_zero, sync_error;

   always #5 clk = ~clk;

   fp_reciprocal_post #(.LATENCY(L)) dut (
      .clk               (clk),
      .rst               (rst),
      .valid_data_in     (valid_data_in),
      .exponent_in       (exponent_in),
      .special_case_in   (special_case_in),
      .special_result_in (special_result_in),
      .invalid_in        (invalid_in),
      .div_by_zero_in    (div_by_zero_in),
      .m_valid           (m_valid),
      .m_mant            (m_mant),
      .m_out_is_1        (m_out_is_1),
      .m_guard           (m_guard),
      .m_round           (m_round),
      .m_sticky          (m_sticky),
      .m_sign            (m_sign),
      .m_rounding_mode   (m_rounding_mode),
      .out               (out),
      .valid_data_out    (valid_data_out),
      .overflow          (overflow),
      .underflow         (underflow),
      .inexact           (inexact),
      .invalid_operation (invalid_operation),
      .div_by_zero       (div_by_zero),
      .sync_error        (sync_error)
   );

   // Per-cycle schedule: sideband issues, mantissa arrivals, expected results
   op_t  sb_op [N];
   bit   sb_v  [N];
   op_t  mm_op [N];
   bit   mm_v  [N];
   res_t ex_r  [N];
   bit   ex_v  [N];
   int   cyc;
   res_t last;
   bit   sync_pending;
   int   n_chk;
   int   n_fail;
   vec_t tbl [17];

   function automatic op_t mk(input logic [7:0] e, input logic is1, input logic [22:0] mant,
                              input logic g, input logic r, input logic s,
                              input logic sign, input logic [2:0] rm);
      op_t o;
      o      = '0;
      o.e    = e;
      o.is1  = is1;
      o.mant = mant;
      o.g    = g;
      o.r    = r;
      o.s    = s;
      o.sign = sign;
      o.rm   = rm;
      return o;
   endfunction

   function automatic op_t mk_sp(input logic [31:0] sres, input logic inv, input logic dbz);
      op_t o;
      o         = '0;
      o.special = 1'b1;
      o.sres    = sres;
      o.inv     = inv;
      o.dbz     = dbz;
      return o;
   endfunction

   // Reference: reciprocal exponent, rounding and exception rules in plain integers
   function automatic res_t model(input op_t o);
      res_t r;
      int   ex;
      int   m;
      bit   inc;
      r = '0;
      if (o.special) begin
         r.out = o.sres;
         r.io  = o.inv;
         r.dz  = o.dbz;
         return r;
      end
      ex = (o.is1 ? 254 : 253) - int'(o.e);
      case (o.rm)
         3'd1:    inc = 1'b0;
         3'd2:    inc = o.sign & (o.g | o.r | o.s);
         3'd3:    inc = !o.sign & (o.g | o.r | o.s);
         3'd4:    inc = o.g;
         default: inc = o.g & (o.r | o.s | o.mant[0]);
      endcase
      if (ex <= 0) begin
         r.out = {o.sign, 31'b0};
         r.uf  = 1'b1;
         r.ix  = 1'b1;
         return r;
      end
      m = int'(o.mant) + int'(inc);
      if (m >= (1 << 23)) begin
         m  = m - (1 << 23);
         ex = ex + 1;
      end
      if (ex >= 255) begin
         r.out = {o.sign, 8'hFF, 23'b0};
         r.ov  = 1'b1;
         r.ix  = 1'b1;
         return r;
      end
      r.out = {o.sign, 8'(ex), 23'(m)};
      r.ix  = o.g | o.r | o.s;
      return r;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      logic [7:0] edge_e [6];
      edge_e = '{8'd0, 8'd1, 8'd252, 8'd253, 8'd254, 8'd255};
      o      = '0;
      o.e    = ($urandom_range(0, 3) == 0) ? edge_e[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
      o.mant = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
      o.is1  = 1'($urandom);
      o.g    = 1'($urandom);
      o.r    = 1'($urandom);
      o.s    = 1'($urandom);
      o.sign = 1'($urandom);
      o.rm   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
         o.special = 1'b1;
         o.sres    = $urandom;
         o.inv     = 1'($urandom);
         o.dbz     = 1'($urandom);
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, req);
      end
   endtask

   task automatic clear_sched();
      for (int i = 0; i < N; i++) begin
         sb_op[i] = '0;
         sb_v[i]  = 1'b0;
         mm_op[i] = '0;
         mm_v[i]  = 1'b0;
         ex_r[i]  = '0;
         ex_v[i]  = 1'b0;
      end
      last         = '0;
      sync_pending = 1'b0;
   endtask

   task automatic drive();
      op_t s;
      op_t m;
      s = sb_op[cyc];
      m = mm_op[cyc];
      valid_data_in     = sb_v[cyc];
      exponent_in       = s.e;
      special_case_in   = s.special;
      special_result_in = s.sres;
      invalid_in        = s.inv;
      div_by_zero_in    = s.dbz;
      m_valid           = mm_v[cyc];
      m_mant            = m.mant;
      m_out_is_1        = m.is1;
      m_guard           = m.g;
      m_round           = m.r;
      m_sticky          = m.s;
      m_sign            = m.sign;
      m_rounding_mode   = m.rm;
   endtask

   task automatic check_outputs();
      res_t want;
      bit   wv;
      bit   exp_sync;
      wv   = ex_v[cyc];
      want = wv ? ex_r[cyc] : last;
`ifdef FP_RECIP_SYNC_CHECK_EN
      exp_sync = sync_pending;
`else
      exp_sync = 1'b0;
`endif
      chk("valid_data_out", {31'b0, valid_data_out}, {31'b0, wv});
      chk("out", out, want.out);
      chk("flags{ov,uf,ix,io,dz}",
          {27'b0, overflow, underflow, inexact, invalid_operation, div_by_zero},
          {27'b0, want.ov, want.uf, want.ix, want.io, want.dz});
      chk("sync_error", {31'b0, sync_error}, {31'b0, exp_sync});
      if (wv) last = want;
   endtask

   task automatic step(input bit do_issue, input bit stray, input op_t op, input res_t ex);
      @(posedge clk);
      #1;
      cyc++;
      if (cyc + L + 2 >= N) begin
         n_fail++;
         $display("FAIL schedule_bound @cycle %0d: got cycle %0d, expected below %0d", cyc, cyc, N - L - 2);
         $fatal(1, "schedule exhausted");
      end
      check_outputs();
      if (do_issue) begin
         sb_v[cyc]        = 1'b1;
         sb_op[cyc]       = op;
         mm_v[cyc+L]      = 1'b1;
         mm_op[cyc+L]     = op;
         ex_v[cyc+L+2]    = 1'b1;
         ex_r[cyc+L+2]    = ex;
      end
      if (stray) begin
         mm_v[cyc]  = 1'b1;
         mm_op[cyc] = op;
      end
      drive();
      if (mm_v[cyc] != ((cyc >= L) ? sb_v[cyc-L] : 1'b0)) sync_pending = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
   endtask

   // Asynchronous pulse inside the current cycle; upstream pipeline is reset too
   task automatic pulse_reset();
      rst = 1'b1;
      clear_sched();
      drive();
      #1;
      chk("reset_valid", {31'b0, valid_data_out}, 32'd0);
      chk("reset_out", out, 32'd0);
      chk("reset_flags", {27'b0, overflow, underflow, inexact, invalid_operation, div_by_zero}, 32'd0);
      chk("reset_sync_error", {31'b0, sync_error}, 32'd0);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      op_t o;
      n_chk  = 0;
      n_fail = 0;
      cyc    = 0;
      clear_sched();
      drive();

      // Flags order in table: {ov, uf, ix, io, dz}
      tbl[0].op  = mk(8'd128, 1'b1, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); tbl[0].ex  = {32'h3F000000, 5'b00000};
      tbl[1].op  = mk(8'd127, 1'b0, 23'h2AAAAA, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0); tbl[1].ex  = {32'h3F2AAAAB, 5'b00100};
      tbl[2].op  = mk(8'd127, 1'b0, 23'h2AAAAA, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1); tbl[2].ex  = {32'h3F2AAAAA, 5'b00100};
      tbl[3].op  = mk(8'd254, 1'b0, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0); tbl[3].ex  = {32'h80000000, 5'b01100};
      tbl[4].op  = mk_sp(32'h7FC00000, 1'b1, 1'b0);                           tbl[4].ex  = {32'h7FC00000, 5'b00010};
      tbl[5].op  = mk_sp(32'h7F800000, 1'b0, 1'b1);                           tbl[5].ex  = {32'h7F800000, 5'b00001};
      tbl[6].op  = mk(8'd0,   1'b1, 23'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4); tbl[6].ex  = {32'h7F800000, 5'b10100};
      tbl[7].op  = mk(8'd127, 1'b0, 23'h7FFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3); tbl[7].ex  = {32'h3F800000, 5'b00100};
      tbl[8].op  = mk(8'd128, 1'b1, 23'h000001, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2); tbl[8].ex  = {32'hBF000002, 5'b00100};
      tbl[9].op  = mk(8'd128, 1'b1, 23'h000002, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0); tbl[9].ex  = {32'h3F000002, 5'b00100};
      tbl[10].op = mk(8'd127, 1'b0, 23'h2AAAAA, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7); tbl[10].ex = {32'h3F2AAAAB, 5'b00100};
      tbl[11].op = mk(8'd253, 1'b0, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); tbl[11].ex = {32'h00000000, 5'b01100};
      tbl[12].op = mk(8'd253, 1'b1, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); tbl[12].ex = {32'h00800000, 5'b00000};
      tbl[13].op = mk(8'd0,   1'b1, 23'h7FFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); tbl[13].ex = {32'h7F7FFFFF, 5'b00000};
      tbl[14].op = mk(8'd0,   1'b1, 23'h7FFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1); tbl[14].ex = {32'hFF7FFFFF, 5'b00100};
      tbl[15].op = mk(8'd128, 1'b1, 23'h000005, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2); tbl[15].ex = {32'h3F000005, 5'b00100};
      tbl[16].op = mk_sp(32'hFF800000, 1'b0, 1'b0);                           tbl[16].ex = {32'hFF800000, 5'b00000};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("init_valid", {31'b0, valid_data_out}, 32'd0);
      chk("init_out", out, 32'd0);
      chk("init_flags", {27'b0, overflow, underflow, inexact, invalid_operation, div_by_zero}, 32'd0);
      chk("init_sync_error", {31'b0, sync_error}, 32'd0);
      rst = 1'b0;

      // Directed table: first back-to-back, then with a bubble after each
      for (int i = 0; i < 17; i++) step(1'b1, 1'b0, tbl[i].op, tbl[i].ex);
      idle(L + 4);
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 1'b0, tbl[i].op, tbl[i].ex);
         idle(1);
      end
      idle(L + 4);

      // 20 back-to-back issues with an asynchronous reset pulse at issue 10
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin
            idle(1);
            pulse_reset();
         end
         o = rand_op();
         step(1'b1, 1'b0, o, model(o));
      end
      idle(L + 4);

      // Randomized stream with bubbles
      for (int i = 0; i < 300; i++) begin
         o = rand_op();
         step(($urandom_range(0, 3) != 0), 1'b0, o, model(o));
      end
      idle(L + 4);

      // Mantissa result with no matching issue
      o = rand_op();
      step(1'b0, 1'b1, o, '0);
      idle(6);
      pulse_reset();
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
